uart_tx_ext: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_ext_if.sv | 12 +
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_ext.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_ext.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity codes
// and the default oversampling ratio.
package uart_pkg;

  typedef logic [4:0] state_t;

  localparam state_t IDLE   = 5'b00001;
  localparam state_t START  = 5'b00010;
  localparam state_t DATA   = 5'b00100;
  localparam state_t PARITY = 5'b01000;
  localparam state_t STOP   = 5'b10000;

  typedef logic [1:0] par_t;

  localparam par_t PAR_NONE = 2'b00;
  localparam par_t PAR_EVEN = 2'b01;
  localparam par_t PAR_ODD  = 2'b10;

  localparam int DEF_OVERSAMPLE = 16;

  // The unused code 2'b11 behaves as "no parity".
  function automatic par_t par_norm(input par_t code);
    return ((code == PAR_EVEN) || (code == PAR_ODD)) ? code : PAR_NONE;
  endfunction

endpackage

// File: rtl/uart_tx_ext_if.sv
// Byte handshake between the bus-side register block (master) and the
// transmitter FIFO (slave).
interface uart_tx_ext_if #(
  parameter int DBIT_MAX = 8
);
  logic [DBIT_MAX-1:0] i_data;
  logic                i_valid;
  logic                o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; the head
// word is visible combinationally on rd_data_o. Shared with the RX side.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_acc, rd_acc;

  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign wr_acc    = wr_en_i & ~full_o;
  assign rd_acc    = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy update; a write rejected while full leaves all state alone.
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// Buffered, runtime-configurable UART transmitter. Words enter a FIFO through
// the valid/ready handshake and are framed as start/data/parity/stop, LSB first.
//
// state  | meaning
// IDLE   | line high, pops the FIFO head and latches frame config when available
// START  | line low for one bit period
// DATA   | shift register bit 0 on the line, nbits periods
// PARITY | latched parity bit on the line, one period
// STOP   | line high for one or two periods; done pulses on the last tick
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int DBIT_MAX   = 8,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_ticks,
  uart_tx_ext_if.slave                bus,
  input  logic [3:0]                  i_cfg_nbits,
  input  logic [1:0]                  i_cfg_parity,
  input  logic                        i_cfg_stop2,
  output logic                        o_busy,
  output logic                        o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        tx
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    NB_MAX    = 4'(DBIT_MAX);

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic [DBIT_MAX-1:0] shift_q, shift_d;
  logic [3:0]          nbits_q, nbits_d;
  par_t                par_q, par_d;
  logic                par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;

  logic                fifo_empty, fifo_full, pop;
  logic [DBIT_MAX-1:0] head;
  logic [3:0]          nbits_eff;
  logic [DBIT_MAX-1:0] masked;
  logic                par_calc;
  logic                bit_end;
  logic                last_stop;

  uart_sync_fifo #(
    .WIDTH (DBIT_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (bus.i_valid),
    .wr_data_i (bus.i_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (o_fifo_count)
  );

  assign bus.o_ready = ~fifo_full;
  assign tx          = tx_q;
  assign bit_end     = i_ticks && (tick_q == TICK_LAST);
  assign last_stop   = ~(stop2_q && (bitcnt_q == 4'd0));

  // Frame parameters derived from the FIFO head and live config, used at pop time.
  always_comb begin
    nbits_eff = ((i_cfg_nbits >= 4'd5) && (i_cfg_nbits <= NB_MAX)) ? i_cfg_nbits : NB_MAX;
    masked    = '0;
    for (int i = 0; i < DBIT_MAX; i++) begin
      masked[i] = head[i] & (i < int'(nbits_eff));
    end
    par_calc = (^masked) ^ (par_norm(i_cfg_parity) == PAR_ODD);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath-next logic; ticks only count outside IDLE.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    par_d     = par_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    if ((state_q != IDLE) && i_ticks) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d   = START;
          tick_d    = '0;
          bitcnt_d  = 4'd0;
          shift_d   = masked;
          nbits_d   = nbits_eff;
          par_d     = par_norm(i_cfg_parity);
          par_bit_d = par_calc;
          stop2_d   = i_cfg_stop2;
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          bitcnt_d = 4'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bitcnt_q == nbits_q - 4'd1) begin
            bitcnt_d = 4'd0;
            state_d  = (par_q == PAR_NONE) ? STOP : PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          bitcnt_d = 4'd0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d  = IDLE;
            bitcnt_d = 4'd0;
          end else begin
            bitcnt_d = 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; the line level is computed from the next state so tx is registered
  // yet changes on the same edge as the state.
  always_comb begin
    o_busy    = (state_q != IDLE);
    pop       = (state_q == IDLE) && !fifo_empty;
    o_tx_done = (state_q == STOP) && bit_end && last_stop && !reset;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= '0;
      bitcnt_q  <= 4'd0;
      shift_q   <= '0;
      nbits_q   <= NB_MAX;
      par_q     <= PAR_NONE;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tick_q    <= tick_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      nbits_q   <= nbits_d;
      par_q     <= par_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ext.sv
// Directed bench for uart_tx_ext: a table of single-frame vectors with
// hand-written line patterns, plus burst, reset, config-change and slow-tick sequences.
module tb_uart_tx_ext;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_ticks = 1'b1;
  logic [3:0] i_cfg_nbits = 4'd8;
  logic [1:0] i_cfg_parity = 2'b00;
  logic       i_cfg_stop2 = 1'b0;
  logic       o_busy, o_tx_done, tx;
  logic [2:0] o_fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 1;
  int div_cnt  = 0;
  int wr_rdy [6];
  int wr_cnt [6];

  uart_tx_ext_if #(.DBIT_MAX(8)) bus ();

  uart_tx_ext #(.DBIT_MAX(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_ticks      (i_ticks),
    .bus          (bus),
    .i_cfg_nbits  (i_cfg_nbits),
    .i_cfg_parity (i_cfg_parity),
    .i_cfg_stop2  (i_cfg_stop2),
    .o_busy       (o_busy),
    .o_tx_done    (o_tx_done),
    .o_fifo_count (o_fifo_count),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  // Baud tick source: every clock, or one clock in tick_div.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_div <= 1) i_ticks = 1'b1;
      else begin
        i_ticks = (div_cnt == 0);
        div_cnt = (div_cnt + 1) % tick_div;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2);
    i_cfg_nbits  = nb;
    i_cfg_parity = par;
    i_cfg_stop2  = s2;
  endtask

  // Drives valid on n consecutive edges regardless of ready; records ready/count after each.
  task automatic write_words(input logic [7:0] w [6], input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = w[k];
      @(posedge clk); #1;
      wr_rdy[k] = int'(bus.o_ready);
      wr_cnt[k] = int'(o_fifo_count);
    end
    bus.i_valid = 1'b0;
  endtask

  // Waits for a start bit, then checks the line clock by clock against the
  // expected pattern (one char per bit, send order). Bit k covers the clocks
  // during which 16k..16k+15 ticks have already been seen in this frame.
  // gap = number of clock edges polled until the line was seen low.
  task automatic run_frame(input string name, input string exp, input int exp_gap,
                           output int clocks);
    int gap, nb, ticks, dones, done_bad, bi;
    int mism [32];
    nb = exp.len();
    clocks = 0;
    for (int b = 0; b < 32; b++) mism[b] = 0;
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while ((tx !== 1'b0) && (gap < 300));
    if (tx !== 1'b0) begin
      chk({name, " start bit timeout"}, 32'(tx), 32'd0);
      return;
    end
    chk({name, " edges to start bit"}, gap, exp_gap);
    ticks = 0; dones = 0; done_bad = 0;
    forever begin
      bi = ticks / OS;
      if (tx !== ((exp[bi] == "1") ? 1'b1 : 1'b0)) mism[bi]++;
      clocks++;
      @(negedge clk); #1;
      if (o_tx_done === 1'b1) begin
        dones++;
        if (!(i_ticks && (ticks == OS * nb - 1))) done_bad++;
      end
      if (i_ticks) ticks++;
      if ((ticks >= OS * nb) || (clocks > 5000)) break;
      @(posedge clk); #1;
    end
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s bit%0d wrong clocks", name, b), mism[b], 0);
    chk({name, " done pulses"}, dones, 1);
    chk({name, " done misplaced"}, done_bad, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] nbits;
    logic [1:0] par;
    logic       stop2;
    string      exp;
  } vec_t;

  vec_t       vt [8];
  logic [7:0] wbuf [6];
  int         c, lows, dones;

  initial begin
    // data, nbits, parity, stop2, line pattern in send order
    vt[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, "0101001011"};
    vt[1] = '{8'h35, 4'd7,  2'b01, 1'b0, "0101011001"};
    vt[2] = '{8'h35, 4'd7,  2'b10, 1'b0, "0101011011"};
    vt[3] = '{8'h1F, 4'd5,  2'b10, 1'b1, "011111011"};
    vt[4] = '{8'hE0, 4'd5,  2'b01, 1'b0, "00000001"};
    vt[5] = '{8'h3C, 4'd15, 2'b11, 1'b0, "0001111001"};
    vt[6] = '{8'h01, 4'd4,  2'b10, 1'b0, "01000000001"};
    vt[7] = '{8'h00, 4'd8,  2'b01, 1'b1, "000000000011"};

    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset ready", 32'(bus.o_ready), 32'd1);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset count", 32'(o_fifo_count), 32'd0);
    @(negedge clk); #1;
    chk("reset done", 32'(o_tx_done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single frames from the table
    for (int k = 0; k < 8; k++) begin
      set_cfg(vt[k].nbits, vt[k].par, vt[k].stop2);
      wbuf[0] = vt[k].data;
      fork
        write_words(wbuf, 1);
        run_frame($sformatf("vec%0d", k), vt[k].exp, 2, c);
      join
      @(posedge clk); #1;
      chk($sformatf("vec%0d busy after", k), 32'(o_busy), 32'd0);
      chk($sformatf("vec%0d idle line", k), 32'(tx), 32'd1);
    end

    // Burst of six writes: five accepted, sent back to back with one idle clock
    set_cfg(4'd8, 2'b00, 1'b0);
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fork
      write_words(wbuf, 6);
      begin
        run_frame("burst0", "0100010001", 2, c);
        run_frame("burst1", "0010001001", 2, c);
        run_frame("burst2", "0110011001", 2, c);
        run_frame("burst3", "0001000101", 2, c);
        run_frame("burst4", "0101010101", 2, c);
      end
    join
    begin
      int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
      int exp_rdy [6] = '{1, 1, 1, 1, 0, 0};
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("burst count after write%0d", k), wr_cnt[k], exp_cnt[k]);
        chk($sformatf("burst ready after write%0d", k), wr_rdy[k], exp_rdy[k]);
      end
    end
    lows = 0;
    repeat (250) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    chk("burst no sixth frame", lows, 0);
    chk("burst fifo drained", 32'(o_fifo_count), 32'd0);

    // Reset during DATA with three words queued
    wbuf = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'h00};
    write_words(wbuf, 4);
    repeat (40) @(posedge clk);
    #1;
    chk("pre-reset queued", 32'(o_fifo_count), 32'd3);
    chk("pre-reset busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("reset cycle done", 32'(o_tx_done), 32'd0);
    @(posedge clk); #1;
    chk("mid reset tx", 32'(tx), 32'd1);
    chk("mid reset count", 32'(o_fifo_count), 32'd0);
    chk("mid reset busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    lows = 0; dones = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
      @(negedge clk); #1;
      if (o_tx_done !== 1'b0) dones++;
    end
    chk("after reset line low clocks", lows, 0);
    chk("after reset done pulses", dones, 0);
    @(posedge clk); #1;

    // Config change mid-frame applies only to the next frame
    set_cfg(4'd8, 2'b00, 1'b0);
    wbuf = '{8'hC3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    fork
      write_words(wbuf, 2);
      begin
        run_frame("cfgchg f0", "0110000111", 2, c);
        run_frame("cfgchg f1", "0010111", 2, c);
      end
      begin
        repeat (60) @(posedge clk);
        #1;
        i_cfg_nbits = 4'd5;
      end
    join
    @(posedge clk); #1;
    chk("cfgchg busy after", 32'(o_busy), 32'd0);

    // Ticks every third clock
    set_cfg(4'd8, 2'b00, 1'b0);
    tick_div = 3;
    repeat (4) @(posedge clk);
    #1;
    wbuf[0] = 8'hA5;
    fork
      write_words(wbuf, 1);
      run_frame("slow", "0101001011", 2, c);
    join
    chk("slow frame clocks within 478..480", 32'((c >= 478) && (c <= 480)), 32'd1);
    tick_div = 1;
    @(posedge clk); #1;
    chk("slow busy after", 32'(o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
